breakout_play_ctrl: RTL and testbench

Game-flow controller for the breakout playfield. Sequences serve, play, life-lost, level-clear and game-over phases, and drives board reset for all block columns. Arbitrates simultaneous block-hit bounce requests from NCOL block-column modules, applying at most one bounce per frame using round-robin fairness. Sits between the block columns, the paddle/ball logic and the top-level VGA game wrapper.

---
 rtl/breakout_play_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_breakout_play_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/breakout_play_ctrl.sv
// Breakout game-flow controller: serve/play/lost/clear/over sequencing plus round-robin block-bounce arbitration.
// Optional BRK_SPEEDUP_EN adds a 2-bit speed output stepped every 16 granted bounces.
module breakout_play_ctrl #(
    parameter int NCOL         = 8,
    parameter int LIVES        = 3,
    parameter int LOCKOUT      = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int CLEAR_SCORE  = 288
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    start,
    input  logic [NCOL-1:0]         hit_u,
    input  logic [NCOL-1:0]         hit_d,
    input  logic [NCOL-1:0]         hit_l,
    input  logic [NCOL-1:0]         hit_r,
    input  logic                    paddle_hit,
    input  logic [1:0]              paddle_zone,
    input  logic                    ball_lost,
    input  logic [9:0]              score_in,
    output logic                    dir_x,
    output logic                    dir_y,
    output logic                    ball_run,
    output logic                    board_reset,
    output logic [1:0]              lives,
    output logic                    level_clear,
    output logic                    game_over,
    output logic [$clog2(NCOL)-1:0] grant_col,
    output logic [7:0]              hit_count
`ifdef BRK_SPEEDUP_EN
    ,
    output logic [1:0]              speed
`endif
);

    localparam int CW = $clog2(NCOL);
    localparam int FW = $clog2(SERVE_FRAMES + 1);
    localparam int LW = $clog2(LOCKOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_LOST,
        S_CLEAR,
        S_OVER
    } state_t;

    state_t          state;
    logic            start_q;
    logic [FW-1:0]   frame_cnt;
    logic [LW-1:0]   lockout;
    logic [CW-1:0]   rr_ptr;
    logic [NCOL-1:0] pend_u, pend_d, pend_l, pend_r;

    logic            start_rise;
    logic [NCOL-1:0] eff_u, eff_d, eff_l, eff_r, eff_any;
    logic [CW-1:0]   pick;
    logic [CW-1:0]   pick_next;
    logic [7:0]      hit_count_inc;
    logic            clear_hit;

    assign start_rise    = start & ~start_q;
    // Hits arriving on the tick cycle itself take part in that tick's decision.
    assign eff_u         = pend_u | hit_u;
    assign eff_d         = pend_d | hit_d;
    assign eff_l         = pend_l | hit_l;
    assign eff_r         = pend_r | hit_r;
    assign eff_any       = eff_u | eff_d | eff_l | eff_r;
    assign pick_next     = (pick == CW'(NCOL - 1)) ? '0 : pick + 1'b1;
    assign hit_count_inc = (hit_count == 8'hFF) ? hit_count : hit_count + 8'd1;
    assign clear_hit     = (score_in >= 10'(CLEAR_SCORE));

    // Round-robin search: the lowest offset from rr_ptr wins, so scan offsets downward.
    always_comb begin
        pick = rr_ptr;
        for (int i = NCOL - 1; i >= 0; i--) begin
            if (eff_any[(int'(rr_ptr) + i) % NCOL]) begin
                pick = CW'((int'(rr_ptr) + i) % NCOL);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            dir_x       <= 1'b1;
            dir_y       <= 1'b0;
            ball_run    <= 1'b0;
            board_reset <= 1'b0;
            lives       <= 2'(LIVES);
            level_clear <= 1'b0;
            game_over   <= 1'b0;
            grant_col   <= '0;
            hit_count   <= '0;
            rr_ptr      <= '0;
            lockout     <= '0;
            frame_cnt   <= '0;
            pend_u      <= '0;
            pend_d      <= '0;
            pend_l      <= '0;
            pend_r      <= '0;
`ifdef BRK_SPEEDUP_EN
            speed       <= '0;
`endif
        end else begin
            start_q     <= start;
            board_reset <= 1'b0;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start_rise) begin
                        state       <= S_SERVE;
                        board_reset <= 1'b1;
                        lives       <= 2'(LIVES);
                        hit_count   <= '0;
                        game_over   <= 1'b0;
                        dir_x       <= 1'b1;
                        dir_y       <= 1'b0;
                        frame_cnt   <= '0;
`ifdef BRK_SPEEDUP_EN
                        speed       <= '0;
`endif
                    end
                end
                S_SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt == FW'(SERVE_FRAMES - 1)) begin
                            state    <= S_PLAY;
                            ball_run <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (ball_lost || clear_hit) begin
                        state    <= ball_lost ? S_LOST : S_CLEAR;
                        ball_run <= 1'b0;
                        if (!ball_lost) begin
                            level_clear <= 1'b1;
                            frame_cnt   <= '0;
                        end
                        pend_u <= '0;
                        pend_d <= '0;
                        pend_l <= '0;
                        pend_r <= '0;
                    end else if (frame_tick && paddle_hit) begin
                        dir_x <= 1'b1;
                        if (paddle_zone == 2'b00) dir_y <= 1'b0;
                        else if (paddle_zone == 2'b10) dir_y <= 1'b1;
                        pend_u <= eff_u;
                        pend_d <= eff_d;
                        pend_l <= eff_l;
                        pend_r <= eff_r;
                    end else if (frame_tick) begin
                        if (lockout != '0) begin
                            lockout <= lockout - 1'b1;
                        end else if (eff_any != '0) begin
                            if (eff_u[pick] && eff_d[pick]) dir_y <= ~dir_y;
                            else if (eff_u[pick])           dir_y <= 1'b0;
                            else if (eff_d[pick])           dir_y <= 1'b1;
                            if (eff_l[pick] && eff_r[pick]) dir_x <= ~dir_x;
                            else if (eff_l[pick])           dir_x <= 1'b0;
                            else if (eff_r[pick])           dir_x <= 1'b1;
                            grant_col <= pick;
                            rr_ptr    <= pick_next;
                            lockout   <= LW'(LOCKOUT);
                            hit_count <= hit_count_inc;
`ifdef BRK_SPEEDUP_EN
                            if (hit_count != 8'hFF && hit_count_inc[3:0] == 4'd0 && speed != 2'd3)
                                speed <= speed + 2'd1;
`endif
                        end
                        pend_u <= '0;
                        pend_d <= '0;
                        pend_l <= '0;
                        pend_r <= '0;
                    end else begin
                        pend_u <= eff_u;
                        pend_d <= eff_d;
                        pend_l <= eff_l;
                        pend_r <= eff_r;
                    end
                end
                S_LOST: begin
                    if (lives == 2'd1) begin
                        lives     <= 2'd0;
                        state     <= S_OVER;
                        game_over <= 1'b1;
                    end else begin
                        lives     <= lives - 2'd1;
                        state     <= S_SERVE;
                        dir_x     <= 1'b1;
                        dir_y     <= 1'b0;
                        frame_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    if (frame_tick) begin
                        if (frame_cnt == FW'(SERVE_FRAMES - 1)) begin
                            state       <= S_SERVE;
                            board_reset <= 1'b1;
                            level_clear <= 1'b0;
                            dir_x       <= 1'b1;
                            dir_y       <= 1'b0;
                            frame_cnt   <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_breakout_play_ctrl.sv
// Bench for breakout_play_ctrl: directed game scenarios with literal expectations, then random play
// checked every cycle against a phase-level behavioural model.
module tb_breakout_play_ctrl;

    localparam int NCOL = 8;
    localparam int LIVES = 3;
    localparam int LOCKOUT = 2;
    localparam int SF = 60;
    localparam int CS = 288;

    localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_LOST = 3, PH_CLEAR = 4, PH_OVER = 5;

    logic clk = 1'b0;
    logic reset, frame_tick, start, paddle_hit, ball_lost;
    logic [NCOL-1:0] hit_u, hit_d, hit_l, hit_r;
    logic [1:0] paddle_zone;
    logic [9:0] score_in;
    logic dir_x, dir_y, ball_run, board_reset, level_clear, game_over;
    logic [1:0] lives;
    logic [$clog2(NCOL)-1:0] grant_col;
    logic [7:0] hit_count;
`ifdef BRK_SPEEDUP_EN
    logic [1:0] speed;
`endif

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    breakout_play_ctrl #(
        .NCOL(NCOL), .LIVES(LIVES), .LOCKOUT(LOCKOUT), .SERVE_FRAMES(SF), .CLEAR_SCORE(CS)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .hit_u(hit_u), .hit_d(hit_d), .hit_l(hit_l), .hit_r(hit_r),
        .paddle_hit(paddle_hit), .paddle_zone(paddle_zone), .ball_lost(ball_lost),
        .score_in(score_in),
        .dir_x(dir_x), .dir_y(dir_y), .ball_run(ball_run), .board_reset(board_reset),
        .lives(lives), .level_clear(level_clear), .game_over(game_over),
        .grant_col(grant_col), .hit_count(hit_count)
`ifdef BRK_SPEEDUP_EN
        , .speed(speed)
`endif
    );

    // Behavioural model: game phase, counters and per-column request flags.
    int m_phase, m_dx, m_dy, m_run, m_br, m_lives, m_clear, m_over;
    int m_gc, m_hc, m_rr, m_lock, m_cnt, m_sq, m_speed;
    bit pu[NCOL], pd[NCOL], pl[NCOL], pr[NCOL];

    task automatic clear_pend();
        for (int c = 0; c < NCOL; c++) begin
            pu[c] = 0; pd[c] = 0; pl[c] = 0; pr[c] = 0;
        end
    endtask

    task automatic enter_serve();
        m_phase = PH_SERVE; m_dx = 1; m_dy = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit rise;
        bit found;
        int g;
        if (reset) begin
            m_phase = PH_IDLE; m_dx = 1; m_dy = 0; m_run = 0; m_br = 0; m_lives = LIVES;
            m_clear = 0; m_over = 0; m_gc = 0; m_hc = 0; m_rr = 0; m_lock = 0; m_cnt = 0;
            m_sq = 0; m_speed = 0;
            clear_pend();
            return;
        end
        rise = start && (m_sq == 0);
        m_sq = start;
        m_br = 0;
        case (m_phase)
            PH_IDLE, PH_OVER: if (rise) begin
                enter_serve();
                m_br = 1; m_lives = LIVES; m_hc = 0; m_over = 0; m_speed = 0;
            end
            PH_SERVE: if (frame_tick) begin
                m_cnt++;
                if (m_cnt == SF) begin m_phase = PH_PLAY; m_run = 1; end
            end
            PH_PLAY: begin
                if (ball_lost) begin
                    m_phase = PH_LOST; m_run = 0; clear_pend();
                end else if (score_in >= CS) begin
                    m_phase = PH_CLEAR; m_run = 0; m_clear = 1; m_cnt = 0; clear_pend();
                end else begin
                    for (int c = 0; c < NCOL; c++) begin
                        pu[c] |= hit_u[c]; pd[c] |= hit_d[c]; pl[c] |= hit_l[c]; pr[c] |= hit_r[c];
                    end
                    if (frame_tick) begin
                        if (paddle_hit) begin
                            m_dx = 1;
                            if (paddle_zone == 0) m_dy = 0;
                            if (paddle_zone == 2) m_dy = 1;
                        end else begin
                            if (m_lock > 0) m_lock--;
                            else begin
                                found = 0; g = 0;
                                for (int k = 0; k < NCOL; k++) begin
                                    int c;
                                    c = (m_rr + k) % NCOL;
                                    if (!found && (pu[c] || pd[c] || pl[c] || pr[c])) begin
                                        found = 1; g = c;
                                    end
                                end
                                if (found) begin
                                    if (pu[g] && pd[g]) m_dy = 1 - m_dy;
                                    else if (pu[g]) m_dy = 0;
                                    else if (pd[g]) m_dy = 1;
                                    if (pl[g] && pr[g]) m_dx = 1 - m_dx;
                                    else if (pl[g]) m_dx = 0;
                                    else if (pr[g]) m_dx = 1;
                                    m_gc = g; m_rr = (g + 1) % NCOL; m_lock = LOCKOUT;
                                    if (m_hc < 255) begin
                                        m_hc++;
                                        if (m_hc % 16 == 0 && m_speed < 3) m_speed++;
                                    end
                                end
                            end
                            clear_pend();
                        end
                    end
                end
            end
            PH_LOST: begin
                if (m_lives == 1) begin m_lives = 0; m_phase = PH_OVER; m_over = 1; end
                else begin m_lives--; enter_serve(); end
            end
            PH_CLEAR: if (frame_tick) begin
                m_cnt++;
                if (m_cnt == SF) begin enter_serve(); m_br = 1; m_clear = 0; end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("dir_x", dir_x, m_dx);
        chk("dir_y", dir_y, m_dy);
        chk("ball_run", ball_run, m_run);
        chk("board_reset", board_reset, m_br);
        chk("lives", lives, m_lives);
        chk("level_clear", level_clear, m_clear);
        chk("game_over", game_over, m_over);
        chk("grant_col", grant_col, m_gc);
        chk("hit_count", hit_count, m_hc);
`ifdef BRK_SPEEDUP_EN
        chk("speed", speed, m_speed);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic ticks(input int n);
        frame_tick = 1;
        repeat (n) step();
        frame_tick = 0;
    endtask

    initial begin
        reset = 1; start = 0; frame_tick = 0; paddle_hit = 0; paddle_zone = 0; ball_lost = 0;
        hit_u = 0; hit_d = 0; hit_l = 0; hit_r = 0; score_in = 0;
        step();
        chk("rst_lives", lives, 3);
        chk("rst_dir_x", dir_x, 1);
        chk("rst_run", ball_run, 0);
        chk("rst_hits", hit_count, 0);
        reset = 0;

        // Start game, serve for 60 frames.
        start = 1; step();
        chk("start_board_reset", board_reset, 1);
        chk("start_lives", lives, 3);
        start = 0; step();
        chk("board_reset_one_cycle", board_reset, 0);
        frame_tick = 1;
        repeat (SF - 1) step();
        chk("serve_59_run", ball_run, 0);
        step();
        frame_tick = 0;
        chk("serve_60_run", ball_run, 1);
        chk("serve_dir_x", dir_x, 1);
        chk("serve_dir_y", dir_y, 0);

        // Two columns hit in one frame; lower column from rr_ptr wins, the other is discarded.
        hit_l = 8'b0000_0100; hit_d = 8'b0010_0000; step();
        hit_l = 0; hit_d = 0;
        frame_tick = 1; step();
        chk("rr_grant_col2", grant_col, 2);
        chk("rr_dir_x0", dir_x, 0);
        chk("rr_count1", hit_count, 1);
        hit_u = 8'b0000_1000; step(); step();
        hit_u = 0;
        chk("lockout_dir_y", dir_y, 0);
        chk("lockout_count", hit_count, 1);
        hit_d = 8'b0010_0000; step();
        hit_d = 0;
        chk("grant_col5", grant_col, 5);
        chk("grant5_dir_y", dir_y, 1);
        chk("grant5_count2", hit_count, 2);

        // Paddle beats a simultaneous block hit; the hit survives to the next tick.
        step(); step();
        paddle_hit = 1; paddle_zone = 2'b00; hit_r = 8'b0000_0010; step();
        paddle_hit = 0; hit_r = 0;
        chk("paddle_dir_x", dir_x, 1);
        chk("paddle_dir_y", dir_y, 0);
        chk("paddle_count", hit_count, 2);
        step();
        chk("after_paddle_col1", grant_col, 1);
        chk("after_paddle_count3", hit_count, 3);
        frame_tick = 0;

        // Level clear and re-serve.
        score_in = 10'd288; step();
        score_in = 0;
        chk("clear_flag", level_clear, 1);
        chk("clear_run", ball_run, 0);
        frame_tick = 1;
        repeat (SF - 1) step();
        chk("clear_59_br", board_reset, 0);
        step();
        frame_tick = 0;
        chk("clear_60_br", board_reset, 1);
        chk("clear_60_flag", level_clear, 0);
        chk("clear_lives", lives, 3);
        chk("clear_hits_kept", hit_count, 3);
        step();
        chk("clear_br_drop", board_reset, 0);

        // Reset in the middle of CLEAR.
        ticks(SF);
        score_in = 10'd300; step();
        score_in = 0;
        ticks(5);
        reset = 1; step();
        chk("midrst_clear", level_clear, 0);
        chk("midrst_br", board_reset, 0);
        chk("midrst_hits", hit_count, 0);
        reset = 0; step();
        chk("midrst_br_after", board_reset, 0);

        // Lose all lives, then restart from game over.
        start = 1; step(); start = 0;
        ticks(SF);
        for (int i = 0; i < 3; i++) begin
            ball_lost = 1; step();
            ball_lost = 0;
            chk("lost_run", ball_run, 0);
            step();
            chk("lost_lives", lives, 2 - i);
            if (i < 2) ticks(SF);
        end
        chk("over_flag", game_over, 1);
        chk("over_run", ball_run, 0);
        start = 1; step(); start = 0;
        chk("restart_lives", lives, 3);
        chk("restart_over", game_over, 0);
        chk("restart_br", board_reset, 1);

        // Random play against the model.
        for (int n = 0; n < 12000; n++) begin
            int r;
            frame_tick = ($urandom_range(2) == 0);
            hit_u = ($urandom_range(3) == 0) ? NCOL'($urandom & $urandom) : '0;
            hit_d = ($urandom_range(3) == 0) ? NCOL'($urandom & $urandom) : '0;
            hit_l = ($urandom_range(3) == 0) ? NCOL'($urandom & $urandom) : '0;
            hit_r = ($urandom_range(3) == 0) ? NCOL'($urandom & $urandom) : '0;
            paddle_hit = ($urandom_range(9) == 0);
            paddle_zone = 2'($urandom_range(3));
            ball_lost = ($urandom_range(299) == 0);
            r = $urandom_range(499);
            if (r == 0) score_in = 10'd288;
            else if (r == 1) score_in = 10'd287;
            else if (r == 2) score_in = 10'($urandom_range(1023, 288));
            else score_in = 10'($urandom_range(287));
            if ($urandom_range(19) == 0) start = ~start;
            reset = ($urandom_range(2999) == 0);
            step();
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
